// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with a double-buffered value,
// frame-boundary commit, anti-ghosting blank window and leading-zero suppression.
module seven_segment_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, ac_val_q, ac_val_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
   logic                    sh_blz_q, sh_blz_d, ac_blz_q, ac_blz_d;
   logic                    pend_q, pend_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    ft_q, ft_d;

   logic                    cnt_wrap, frame_wrap, lz_blank;
   logic [4*NUM_DIGITS-1:0] upper;
   logic [NUM_DIGITS-1:0]   dig_raw;

   always_comb begin
      cnt_wrap   = (cnt_q == CNT_LAST);
      frame_wrap = cnt_wrap && (idx_q == IDX_LAST);

      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      // Shadow always follows load so a later commit never reverts a direct write.
      sh_val_d = sh_val_q;
      sh_dp_d  = sh_dp_q;
      sh_blz_d = sh_blz_q;
      if (load) begin
         sh_val_d = value;
         sh_dp_d  = dp_in;
         sh_blz_d = blank_lz;
      end

      ac_val_d = ac_val_q;
      ac_dp_d  = ac_dp_q;
      ac_blz_d = ac_blz_q;
      if (frame_wrap) begin
         ac_val_d = sh_val_d;
         ac_dp_d  = sh_dp_d;
         ac_blz_d = sh_blz_d;
      end

      pend_d = frame_wrap ? 1'b0 : (load ? 1'b1 : pend_q);

      upper    = ac_val_q >> {idx_q, 2'b00};
      lz_blank = ac_blz_q && (idx_q != '0) && (upper == '0);
      seg_d    = (lz_blank ? 7'h00 : hex7(upper[3:0])) ^ SEG_OFF;
      dp_d     = ac_dp_q[idx_q] ^ SEG_ACTIVE_LOW;

      dig_raw = '0;
      if (cnt_q >= BLANK_END) dig_raw[idx_q] = 1'b1;
      dig_d = dig_raw ^ DIG_OFF;

      ft_d = frame_wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         sh_val_q <= '0;
         sh_dp_q  <= '0;
         sh_blz_q <= 1'b0;
         ac_val_q <= '0;
         ac_dp_q  <= '0;
         ac_blz_q <= 1'b0;
         pend_q   <= 1'b0;
         seg_q    <= SEG_OFF;
         dp_q     <= SEG_ACTIVE_LOW;
         dig_q    <= DIG_OFF;
         ft_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         sh_val_q <= sh_val_d;
         sh_dp_q  <= sh_dp_d;
         sh_blz_q <= sh_blz_d;
         ac_val_q <= ac_val_d;
         ac_dp_q  <= ac_dp_d;
         ac_blz_q <= ac_blz_d;
         pend_q   <= pend_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         dig_q    <= dig_d;
         ft_q     <= ft_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign dig_sel    = dig_q;
   assign frame_tick = ft_q;
   assign pending    = pend_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: directed scenarios plus random loads, all
// checked each cycle against a cycle-count based reference model.
module tb_seven_segment_scan_driver;

   localparam int ND    = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ND * DIV;

   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic        frame_tick;
   logic        pending;

   seven_segment_scan_driver #(
      .NUM_DIGITS(ND), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg), .dp(dp), .dig_sel(dig_sel),
      .frame_tick(frame_tick), .pending(pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: position in the scan is derived purely from the number of
   // clocks since reset; m_t counts rising edges since reset release.
   int          m_t = 0;
   int          m_cnt, m_idx;
   logic [15:0] sh_v = '0, ac_v = '0, m_upper;
   logic [3:0]  sh_d = '0, ac_d = '0;
   logic        sh_b = 1'b0, ac_b = 1'b0, m_pend = 1'b0, m_wrap;
   logic [6:0]  e_seg = 7'h00;
   logic        e_dp = 1'b0, e_ft = 1'b0;
   logic [3:0]  e_dig = 4'hF;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; sh_v = '0; ac_v = '0; sh_d = '0; ac_d = '0;
         sh_b = 1'b0; ac_b = 1'b0; m_pend = 1'b0;
         e_seg = 7'h00; e_dp = 1'b0; e_ft = 1'b0; e_dig = 4'hF;
      end else begin
         m_cnt   = m_t % DIV;
         m_idx   = (m_t / DIV) % ND;
         m_upper = ac_v >> (4 * m_idx);
         e_dig   = (m_cnt < BLANK) ? 4'hF : ~(4'b0001 << m_idx);
         e_seg   = (ac_b && m_idx != 0 && m_upper == 16'h0) ? 7'h00 : HEX[m_upper[3:0]];
         e_dp    = ac_d[m_idx];
         m_wrap  = (m_t % FRAME) == FRAME - 1;
         e_ft    = m_wrap;
         if (m_wrap) begin
            if (load) begin ac_v = value; ac_d = dp_in; ac_b = blank_lz; end
            else begin ac_v = sh_v; ac_d = sh_d; ac_b = sh_b; end
            m_pend = 1'b0;
         end
         if (load) begin
            sh_v = value; sh_d = dp_in; sh_b = blank_lz;
            if (!m_wrap) m_pend = 1'b1;
         end
         m_t++;
      end
   end

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("seg", 32'(seg), 32'(e_seg));
         check_eq("dp", 32'(dp), 32'(e_dp));
         check_eq("dig_sel", 32'(dig_sel), 32'(e_dig));
         check_eq("frame_tick", 32'(frame_tick), 32'(e_ft));
         check_eq("pending", 32'(pending), 32'(m_pend));
         check_eq("one_hot", 32'($countones(~dig_sel) <= 1), 32'd1);
      end
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
      load = 1'b1; value = v; dp_in = d; blank_lz = b;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_t(input int tgt);
      int k = 0;
      while ((m_t % FRAME) != tgt && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2 * FRAME) check_eq("wait_phase_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ft();
      int k = 0;
      while (frame_tick !== 1'b1 && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2 * FRAME) check_eq("frame_tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_dig_sel", 32'(dig_sel), 32'hF);
      check_eq("rst_seg", 32'(seg), 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Idle scan of the reset value.
      repeat (70) @(negedge clk);

      // Mid-frame load, held until the frame boundary.
      wait_t(13);
      do_load(16'hA3F5, 4'b0100, 1'b0);
      check_eq("t2_pending_set", 32'(pending), 32'd1);
      wait_ft();
      check_eq("t2_pending_clr", 32'(pending), 32'd0);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (dig_sel == 4'b1011) begin
            check_eq("t2_d2_seg", 32'(seg), 32'h4F);
            check_eq("t2_d2_dp", 32'(dp), 32'd1);
         end
      end

      // Leading-zero suppression.
      do_load(16'h0042, 4'b0000, 1'b1);
      wait_ft();
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (dig_sel == 4'b0111) check_eq("t3_d3_blank", 32'(seg), 32'h0);
         if (dig_sel == 4'b1101) check_eq("t3_d1_seg", 32'(seg), 32'h66);
      end
      do_load(16'h0000, 4'b0000, 1'b1);
      wait_ft();
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (dig_sel == 4'b1101) check_eq("t3_zero_d1_blank", 32'(seg), 32'h0);
         if (dig_sel == 4'b1110) check_eq("t3_zero_d0_seg", 32'(seg), 32'h3F);
      end

      // Two loads within one frame: only the last is committed.
      wait_t(3);
      do_load(16'h1111, 4'b0000, 1'b0);
      do_load(16'h2222, 4'b0000, 1'b0);
      wait_ft();
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (dig_sel != 4'hF) check_eq("t4_last_wins", 32'(seg), 32'h5B);
      end

      // Load coinciding with the commit clock.
      wait_t(FRAME - 1);
      do_load(16'h5A5A, 4'b1001, 1'b0);
      check_eq("t5_frame_tick", 32'(frame_tick), 32'd1);
      check_eq("t5_pending", 32'(pending), 32'd0);
      repeat (40) @(negedge clk);

      // Random loads at random times.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            load     = 1'b1;
            value    = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      repeat (10) @(negedge clk);

      // Reset mid-frame at cnt=5, idx=2.
      wait_t(2 * DIV + 5);
      #2 rst = 1'b1;
      #1;
      check_eq("t6_rst_dig_sel", 32'(dig_sel), 32'hF);
      check_eq("t6_rst_seg", 32'(seg), 32'h0);
      check_eq("t6_rst_dp", 32'(dp), 32'h0);
      check_eq("t6_rst_pending", 32'(pending), 32'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (dig_sel != 4'hF) break;
      end
      check_eq("t6_first_cycle", 32'(n), 32'd3);
      check_eq("t6_first_digit", 32'(dig_sel), 32'b1110);
      check_eq("t6_first_seg", 32'(seg), 32'h3F);
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
